// File: rtl/microc_pkg.sv
// Shared constants for the microcontroller core: instruction field positions,
// PC width and ALU op-codes.
package microc_pkg;

   localparam int unsigned PC_W     = 10;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPC_W    = 6;
   localparam int unsigned OP_W     = 3;
   localparam int unsigned RF_AW    = 4;
   localparam int unsigned RF_DEPTH = 16;
   localparam int unsigned IMM_W    = 8;

   // Instruction field bit positions
   localparam int unsigned OPC_MSB  = 15;
   localparam int unsigned OPC_LSB  = 10;
   localparam int unsigned RA1_MSB  = 11;
   localparam int unsigned RA1_LSB  = 8;
   localparam int unsigned RA2_MSB  = 7;
   localparam int unsigned RA2_LSB  = 4;
   localparam int unsigned WA_MSB   = 3;
   localparam int unsigned WA_LSB   = 0;
   localparam int unsigned IMM_MSB  = 11;
   localparam int unsigned IMM_LSB  = 4;
   localparam int unsigned JMP_MSB  = 9;
   localparam int unsigned JMP_LSB  = 0;

   typedef enum logic [OP_W-1:0] {
      ALU_PASS_A = 3'b000,
      ALU_NOT_A  = 3'b001,
      ALU_ADD    = 3'b010,
      ALU_SUB    = 3'b011,
      ALU_AND    = 3'b100,
      ALU_OR     = 3'b101,
      ALU_NEG_A  = 3'b110,
      ALU_NEG_B  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/microc_stack_ret_stack.sv
// Return-address LIFO: push writes above the top, pop exposes the entry below.
// Entry contents are not reset; only the occupancy counter is.
module ret_stack
   import microc_pkg::*;
#(
   parameter int unsigned DATA_W = PC_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_W-1:0]            din,
   output logic [DATA_W-1:0]            dout,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned AW    = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_depth;
   logic              w_do_push;
   logic              w_do_pop;
   logic [AW-1:0]     w_wr_idx;
   logic [AW-1:0]     w_top_idx;

   assign full      = (r_depth == CNT_W'(DEPTH));
   assign empty     = (r_depth == CNT_W'(0));
   // Pop wins over a simultaneous push; overflowing pushes are dropped
   assign w_do_pop  = reset & pop & ~empty;
   assign w_do_push = reset & push & ~pop & ~full;
   assign w_wr_idx  = AW'(r_depth);
   assign w_top_idx = AW'(r_depth - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_depth <= '0;
      end else if (w_do_pop) begin
         r_depth <= r_depth - CNT_W'(1);
      end else if (w_do_push) begin
         r_depth <= r_depth + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= din;
      end
   end

   assign dout  = r_mem[w_top_idx];
   assign depth = r_depth;

endmodule

// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath: PC sequencing with call/return stack,
// 16-entry register file, 8-function ALU and registered zero flag.
module microc_stack
   import microc_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                en,
   input  logic [INSTR_W-1:0]                  instr,
   input  logic                                s_inc,
   input  logic                                s_inm,
   input  logic                                we3,
   input  logic                                wez,
   input  logic                                s_call,
   input  logic                                s_ret,
   input  logic [OP_W-1:0]                     Op,
   output logic [PC_W-1:0]                     pc,
   output logic [OPC_W-1:0]                    Opcode,
   output logic                                z,
   output logic [$clog2(STACK_DEPTH+1)-1:0]    depth,
   output logic                                ovf,
   output logic                                unf
);

   logic [DATA_W-1:0] r_rf [RF_DEPTH];
   logic [PC_W-1:0]   r_pc;
   logic              r_z;
   logic              r_ovf;
   logic              r_unf;

   logic [RF_AW-1:0]  w_ra1;
   logic [RF_AW-1:0]  w_ra2;
   logic [RF_AW-1:0]  w_wa;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [DATA_W-1:0] w_imm;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_result;

   logic [PC_W-1:0]   w_pc_inc;
   logic [PC_W-1:0]   w_pc_next;
   logic [PC_W-1:0]   w_stk_top;
   logic              w_push;
   logic              w_pop;
   logic              w_set_ovf;
   logic              w_set_unf;
   logic              w_stk_full;
   logic              w_stk_empty;

   // Register-file read and operand selection; r0 is hard-wired to zero
   assign w_ra1 = instr[RA1_MSB:RA1_LSB];
   assign w_ra2 = s_inm ? instr[WA_MSB:WA_LSB] : instr[RA2_MSB:RA2_LSB];
   assign w_wa  = instr[WA_MSB:WA_LSB];
   assign w_rd1 = (w_ra1 == RF_AW'(0)) ? '0 : r_rf[w_ra1];
   assign w_rd2 = (w_ra2 == RF_AW'(0)) ? '0 : r_rf[w_ra2];
   assign w_imm = DATA_W'(instr[IMM_MSB:IMM_LSB]);
   assign w_a   = s_inm ? w_imm : w_rd1;
   assign w_b   = w_rd2;

   always_comb begin
      w_result = '0;
      case (alu_op_e'(Op))
         ALU_PASS_A: w_result = w_a;
         ALU_NOT_A:  w_result = ~w_a;
         ALU_ADD:    w_result = w_a + w_b;
         ALU_SUB:    w_result = w_a - w_b;
         ALU_AND:    w_result = w_a & w_b;
         ALU_OR:     w_result = w_a | w_b;
         ALU_NEG_A:  w_result = DATA_W'(0) - w_a;
         ALU_NEG_B:  w_result = DATA_W'(0) - w_b;
         default:    w_result = '0;
      endcase
   end

   // Writes are blocked during reset so the file only changes on real instructions
   always_ff @(posedge clk) begin
      if (reset && en && we3 && (w_wa != RF_AW'(0))) begin
         r_rf[w_wa] <= w_result;
      end
   end

   // Next-PC selection: return beats jump/call, which beats sequential
   assign w_pc_inc = r_pc + PC_W'(1);

   always_comb begin
      w_pc_next = w_pc_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (s_ret) begin
         if (!w_stk_empty) begin
            w_pc_next = w_stk_top;
            w_pop     = 1'b1;
         end else begin
            w_set_unf = 1'b1;
         end
      end else if (!s_inc) begin
         w_pc_next = instr[JMP_MSB:JMP_LSB];
         if (s_call) begin
            if (!w_stk_full) begin
               w_push = 1'b1;
            end else begin
               w_set_ovf = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc  <= '0;
         r_z   <= 1'b0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (en) begin
         r_pc <= w_pc_next;
         if (wez) begin
            r_z <= (w_result == DATA_W'(0));
         end
         if (w_set_ovf) begin
            r_ovf <= 1'b1;
         end
         if (w_set_unf) begin
            r_unf <= 1'b1;
         end
      end
   end

   ret_stack #(
      .DATA_W (PC_W),
      .DEPTH  (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (w_push & en),
      .pop   (w_pop & en),
      .din   (w_pc_inc),
      .dout  (w_stk_top),
      .depth (depth),
      .full  (w_stk_full),
      .empty (w_stk_empty)
   );

   assign pc     = r_pc;
   assign z      = r_z;
   assign ovf    = r_ovf;
   assign unf    = r_unf;
   assign Opcode = instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_microc_stack.sv
// Scoreboard bench for microc_stack: a behavioural model queues expected state
// per applied instruction; each entry is popped and compared after the edge.
module tb_microc_stack;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned SD     = 4;

   logic        clk = 1'b0;
   logic        reset, en, s_inc, s_inm, we3, wez, s_call, s_ret;
   logic [15:0] instr;
   logic [2:0]  Op;
   logic [9:0]  pc;
   logic [5:0]  Opcode;
   logic        z, ovf, unf;
   logic [2:0]  depth;

   microc_stack #(.DATA_W(DATA_W), .STACK_DEPTH(SD)) dut (
      .clk(clk), .reset(reset), .en(en), .instr(instr), .s_inc(s_inc),
      .s_inm(s_inm), .we3(we3), .wez(wez), .s_call(s_call), .s_ret(s_ret),
      .Op(Op), .pc(pc), .Opcode(Opcode), .z(z), .depth(depth), .ovf(ovf),
      .unf(unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] pc;
      logic       z;
      logic [2:0] depth;
      logic       ovf;
      logic       unf;
      logic [5:0] opc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference state
   logic [7:0] m_rf [16];
   logic [9:0] m_stk [SD];
   logic [9:0] m_pc;
   logic       m_z, m_ovf, m_unf;
   int         m_depth;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model(input logic rst, input logic e, input logic [15:0] ins,
                        input logic inc, input logic inm, input logic w3,
                        input logic wz, input logic cl, input logic rt,
                        input logic [2:0] op);
      logic [7:0] a, b, rd1, rd2, res;
      logic [3:0] ra2;
      if (!rst) begin
         m_pc = '0; m_z = 1'b0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
         return;
      end
      if (!e) return;
      rd1 = (ins[11:8] == 4'd0) ? 8'd0 : m_rf[ins[11:8]];
      ra2 = inm ? ins[3:0] : ins[7:4];
      rd2 = (ra2 == 4'd0) ? 8'd0 : m_rf[ra2];
      a = inm ? ins[11:4] : rd1;
      b = rd2;
      case (op)
         3'd0: res = a;
         3'd1: res = ~a;
         3'd2: res = a + b;
         3'd3: res = a - b;
         3'd4: res = a & b;
         3'd5: res = a | b;
         3'd6: res = 8'd0 - a;
         default: res = 8'd0 - b;
      endcase
      if (w3 && ins[3:0] != 4'd0) m_rf[ins[3:0]] = res;
      if (wz) m_z = (res == 8'd0);
      if (rt) begin
         if (m_depth > 0) begin
            m_depth--;
            m_pc = m_stk[m_depth];
         end else begin
            m_pc = m_pc + 10'd1;
            m_unf = 1'b1;
         end
      end else if (!inc) begin
         if (cl) begin
            if (m_depth < SD) begin
               m_stk[m_depth] = m_pc + 10'd1;
               m_depth++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_pc = ins[9:0];
      end else begin
         m_pc = m_pc + 10'd1;
      end
   endtask

   task automatic apply(input logic rst, input logic e, input logic [15:0] ins,
                        input logic inc, input logic inm, input logic w3,
                        input logic wz, input logic cl, input logic rt,
                        input logic [2:0] op);
      exp_t x, g;
      reset = rst; en = e; instr = ins; s_inc = inc; s_inm = inm; we3 = w3;
      wez = wz; s_call = cl; s_ret = rt; Op = op;
      model(rst, e, ins, inc, inm, w3, wz, cl, rt, op);
      x.pc = m_pc; x.z = m_z; x.depth = 3'(m_depth); x.ovf = m_ovf;
      x.unf = m_unf; x.opc = ins[15:10];
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      chk("pc", 32'(pc), 32'(g.pc));
      chk("z", 32'(z), 32'(g.z));
      chk("depth", 32'(depth), 32'(g.depth));
      chk("ovf", 32'(ovf), 32'(g.ovf));
      chk("unf", 32'(unf), 32'(g.unf));
      chk("opcode", 32'(Opcode), 32'(g.opc));
   endtask

   task automatic ldi(input logic [3:0] rd, input logic [7:0] v);
      apply(1, 1, {4'h0, v, rd}, 1, 1, 1, 0, 0, 0, 3'd0);
   endtask

   // z <= (v - r[rd] == 0), no register write
   task automatic probe(input logic [3:0] rd, input logic [7:0] v);
      apply(1, 1, {4'h0, v, rd}, 1, 1, 0, 1, 0, 0, 3'd3);
   endtask

   task automatic alu_rr(input logic [2:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rd);
      apply(1, 1, {4'h0, ra, rb, rd}, 1, 0, 1, 1, 0, 0, op);
   endtask

   task automatic jmp(input logic [9:0] t);
      apply(1, 1, {6'h00, t}, 0, 0, 0, 0, 0, 0, 3'd0);
   endtask

   task automatic call(input logic [9:0] t);
      apply(1, 1, {6'h2a, t}, 0, 0, 0, 0, 1, 0, 3'd0);
   endtask

   task automatic ret();
      apply(1, 1, 16'hfc00, 1, 0, 0, 0, 0, 1, 3'd0);
   endtask

   initial begin
      logic [9:0] p0;
      // Reset held two cycles
      apply(0, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 3'd0);
      apply(0, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 3'd0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_depth", 32'(depth), 32'h0);

      // Immediates, SUB to zero, register probes
      ldi(4'd1, 8'd5);
      ldi(4'd2, 8'd5);
      alu_rr(3'd3, 4'd1, 4'd2, 4'd3);
      chk("sub_z", 32'(z), 32'h1);
      apply(1, 1, {4'h0, 4'h0, 4'd3, 4'h0}, 1, 0, 0, 1, 0, 0, 3'd7);
      probe(4'd1, 8'd5);
      probe(4'd1, 8'd6);
      chk("probe_ne_z", 32'(z), 32'h0);

      // 0xFF + 0x01 wraps to zero; 5 + 1 does not
      ldi(4'd4, 8'hff);
      ldi(4'd5, 8'h01);
      alu_rr(3'd2, 4'd4, 4'd5, 4'd6);
      chk("add_wrap_z", 32'(z), 32'h1);
      alu_rr(3'd2, 4'd1, 4'd5, 4'd7);
      probe(4'd7, 8'd6);
      // Remaining ALU functions
      alu_rr(3'd1, 4'd4, 4'd0, 4'd8);
      alu_rr(3'd4, 4'd4, 4'd1, 4'd9);
      alu_rr(3'd5, 4'd1, 4'd5, 4'd10);
      alu_rr(3'd6, 4'd1, 4'd0, 4'd11);
      probe(4'd11, 8'hfb);
      alu_rr(3'd0, 4'd4, 4'd0, 4'd12);
      probe(4'd12, 8'hff);

      // Call and return
      jmp(10'h010);
      call(10'h100);
      chk("call_pc", 32'(pc), 32'h100);
      chk("call_depth", 32'(depth), 32'h1);
      ret();
      chk("ret_pc", 32'(pc), 32'h011);

      // Five nested calls then five returns
      p0 = pc;
      call(10'h200); call(10'h210); call(10'h220); call(10'h230); call(10'h240);
      chk("ovf_pc", 32'(pc), 32'h240);
      chk("ovf_depth", 32'(depth), 32'h4);
      chk("ovf_flag", 32'(ovf), 32'h1);
      ret(); chk("ret1", 32'(pc), 32'h221);
      ret(); ret(); ret();
      chk("ret4", 32'(pc), 32'(p0 + 10'd1));
      ret();
      chk("unf_pc", 32'(pc), 32'(p0 + 10'd2));
      chk("unf_flag", 32'(unf), 32'h1);

      // en=0 freezes everything, then verify r3 untouched
      apply(1, 0, {4'h0, 8'h77, 4'd3}, 0, 1, 1, 1, 1, 0, 3'd0);
      probe(4'd3, 8'h00);
      chk("en0_r3_z", 32'(z), 32'h1);

      // Reset clears flags; call+ret at depth 1 is a pure pop
      apply(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 3'd0);
      jmp(10'h040);
      call(10'h080);
      apply(1, 1, {6'h00, 10'h300}, 0, 0, 0, 0, 1, 1, 3'd0);
      chk("callret_pc", 32'(pc), 32'h041);
      chk("callret_depth", 32'(depth), 32'h0);

      // r0 stays zero; PC wraps
      ldi(4'd0, 8'h55);
      apply(1, 1, {4'h0, 4'h0, 4'd0, 4'h0}, 1, 0, 0, 1, 0, 0, 3'd7);
      chk("r0_z", 32'(z), 32'h1);
      jmp(10'h3ff);
      apply(1, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 3'd0);
      chk("wrap_pc", 32'(pc), 32'h0);

      // Reset during calls discards return addresses
      call(10'h100); call(10'h110);
      apply(0, 1, 16'h0000, 0, 0, 0, 0, 1, 0, 3'd0);
      ret();
      chk("rst_call_pc", 32'(pc), 32'h1);
      chk("rst_call_unf", 32'(unf), 32'h1);

      // Random traffic with every register initialised
      for (int i = 1; i < 16; i++) ldi(4'(i), 8'($urandom));
      for (int i = 0; i < 300; i++) begin
         apply(($urandom_range(0, 29) != 0), ($urandom_range(0, 7) != 0),
               16'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), 3'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
